axi_lite_slave_regs: RTL
========================

// Module: axi_lite_slave_regs
// PURPOSE
//  AXI4-Lite slave register bank; the downstream target of our AXI4-Lite master test stage.
//  Holds C_NUM_REGS 32-bit registers at C_BASEADDR.
//  Accepts single-beat writes (with byte strobes) and serves readback, so the master's
//  write/verify sequence can close on-chip.
//  Also emits a one-cycle write-commit strobe to user logic.
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH  32            address width
//  C_S_AXI_DATA_WIDTH  32            data width; only 32 is supported
//  C_NUM_REGS          16            number of registers, 1..256
//  C_BASEADDR          32'h88000000  byte address of register 0; registers sit at 4-byte stride
// PORTS
//  S_AXI_ACLK     in   1   clock
//  S_AXI_ARESETN  in   1   reset, asynchronous assert, active-low
//  S_AXI_AWADDR   in   32  write address
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID  in   1   / S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte enables
//  S_AXI_WVALID   in   1   / S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2   write response
//  S_AXI_BVALID   out  1   / S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   32  read address
//  S_AXI_ARPROT   in   3   ignored
//  S_AXI_ARVALID  in   1   / S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   read response
//  S_AXI_RVALID   out  1   / S_AXI_RREADY in 1
//  REG_WR_STROBE  out  1   one-cycle pulse on each in-range write commit
//  REG_WR_INDEX   out  8   register index of the last commit
// BEHAVIOUR
//  Reset (async, ARESETN=0):
//   - all registers=0; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0; REG_WR_STROBE=0; REG_WR_INDEX=0.
//   - AWREADY/WREADY/ARREADY=0 while in reset and for the first edge after release (registered 'up' flag).
//   - Reset mid-transaction discards all held address/data; no response is issued for it.
//  Decode:
//   - off = addr - C_BASEADDR; idx = off[9:2]; addr[1:0] ignored.
//   - In range iff addr >= C_BASEADDR and idx < C_NUM_REGS.
//  Write FSM (W_IDLE, W_RESP):
//   - W_IDLE: AWREADY = ~aw_held; WREADY = ~w_held. AW and W are accepted in either order or the same cycle.
//     Each is latched into a holding reg and its held flag is set.
//   - Commit edge: both present (held or handshaking this cycle).
//     - In range: bytes with WSTRB[i]=1 update reg[idx][8i+7:8i]; REG_WR_STROBE=1 for exactly that following cycle.
//     - Held flags clear; BVALID=1 next cycle; go to W_RESP.
//   - W_RESP: AWREADY=WREADY=0. BVALID/BRESP held stable until BREADY. On the BVALID&BREADY edge: BVALID=0, back to W_IDLE.
//   - Write latency: AW+W same cycle N -> register updated and BVALID high in cycle N+1.
//   - Throughput: one write per 2 cycles minimum when BREADY=1.
//  Read FSM (R_IDLE, R_DATA):
//   - R_IDLE: ARREADY=1. On ARVALID&ARREADY: RDATA = reg[idx] sampled at that edge; RVALID=1 in next cycle; go to R_DATA.
//   - R_DATA: ARREADY=0. RDATA/RRESP held stable until RREADY. On RVALID&RREADY: RVALID=0, back to R_IDLE.
//   - Read latency: 1 cycle AR handshake -> RVALID.
//  Simultaneous events:
//   - Read and write channels are independent.
//   - AR handshake on the same edge as a commit to the same register returns the OLD value.
//   - The next read returns the new value.
//  Out-of-range write: register bank unchanged, no REG_WR_STROBE; response per CONFIGURATION.
//  Out-of-range read: RDATA=0; response per CONFIGURATION.
//  VALID outputs never drop without a handshake. RDATA/BRESP never change while VALID is high.
// CONFIGURATION
//  `AXI_LITE_SLAVE_DECERR_EN
//   - Defined: out-of-range write -> BRESP=2'b11; out-of-range read -> RRESP=2'b11, RDATA=0.
//   - Undefined: out-of-range accesses respond OKAY (2'b00). Writes are silently dropped; reads return 0.
//  In-range accesses always respond OKAY.
// TESTING
//  1. Reset release -> READYs low for 1 cycle, then AWREADY=WREADY=ARREADY=1; all reads return 0.
//  2. Same-cycle AW=0x88000008, W=0xA5A5A5A5, STRB=4'hF -> BVALID next cycle, BRESP=00, REG_WR_STROBE 1 cycle, INDEX=2.
//     Read 0x88000008 -> 0xA5A5A5A5 one cycle after AR.
//  3. W (0x11223344, STRB=4'b0101) 3 cycles before AW=0x88000000, BREADY low 5 cycles
//     -> BVALID held; AW/WREADY stay 0; reg0=0x00220044.
//  4. Drive our AXI4-Lite master (16 writes of i to 0x88000000+(i-1)*4, then readback) against this block
//     -> DONE_SUCCESS=1, no error response.
//  5. Write/read 0x88000040 (idx 16): with DECERR_EN -> BRESP=RRESP=11, RDATA=0; without -> 00/00, RDATA=0;
//     reg bank unchanged in both.
//  6. Assert ARESETN low while BVALID=1 and RVALID=1 -> both drop immediately; post-release reads of reg0 return 0.

Source files
------------

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
//   AXI4-Lite slave register bank: C_NUM_REGS 32-bit registers at C_BASEADDR
//   (4-byte stride). Single-beat writes with byte strobes, single-beat reads,
//   plus a one-cycle commit strobe to user logic.
//
//   Build option: define AXI_LITE_SLAVE_DECERR_EN to answer out-of-range
//   accesses with DECERR (2'b11); otherwise they answer OKAY. In both cases,
//   out-of-range writes are dropped and out-of-range reads return 0.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN        clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address / data / response channels
//   S_AXI_AR* / S_AXI_R*             read address / data channels
//   S_AXI_AWPROT, S_AXI_ARPROT       ignored
//   REG_WR_STROBE                    one-cycle pulse per in-range write commit
//   REG_WR_INDEX                     register index of the last commit
module axi_lite_slave_regs #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_REGS         = 16,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'h88000000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              REG_WR_STROBE,
  output logic [7:0]                        REG_WR_INDEX
);

  localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB     = DW / 8;
  localparam int unsigned IDX_W  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int unsigned NSLOT  = 1 << IDX_W;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLAVE_DECERR_EN
  localparam logic [1:0]  RESP_OOR  = 2'b11;
`else
  localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic          up;
  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [NB-1:0] w_strb_q;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0] wr_addr, wr_off, rd_off;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_strb;
  logic [7:0]    wr_idx, rd_idx;
  logic          wr_in_range, rd_in_range;
  logic [DW-1:0] regs [NSLOT];
  logic          unused_sigs;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] data,
                                          input logic [NB-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int unsigned b = 0; b < NB; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A commit uses the held copy of whichever half arrived earlier and the
  // live bus for the half handshaking this cycle.
  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
  assign commit  = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

  // The lower-address check matters: below-base addresses can wrap to a small idx.
  assign wr_off      = wr_addr - C_BASEADDR;
  assign wr_idx      = wr_off[9:2];
  assign wr_in_range = (wr_addr >= C_BASEADDR) && ({1'b0, wr_idx} < 9'(C_NUM_REGS));
  assign rd_off      = S_AXI_ARADDR - C_BASEADDR;
  assign rd_idx      = rd_off[9:2];
  assign rd_in_range = (S_AXI_ARADDR >= C_BASEADDR) && ({1'b0, rd_idx} < 9'(C_NUM_REGS));

  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_off[AW-1:10], wr_off[1:0],
                         rd_off[AW-1:10], rd_off[1:0]};

  // READYs stay low for the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) up <= 1'b0;
    else                up <= 1'b1;
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (commit)       w_state_nxt = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default:                  w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = up & (w_state == W_IDLE) & ~aw_held;
    S_AXI_WREADY  = up & (w_state == W_IDLE) & ~w_held;
    S_AXI_BVALID  = (w_state == W_RESP);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_BRESP   <= RESP_OKAY;
      REG_WR_STROBE <= 1'b0;
      REG_WR_INDEX  <= '0;
    end else begin
      REG_WR_STROBE <= 1'b0;
      if (commit) begin
        if (wr_in_range) begin
          S_AXI_BRESP   <= RESP_OKAY;
          REG_WR_STROBE <= 1'b1;
          REG_WR_INDEX  <= wr_idx;
        end else begin
          S_AXI_BRESP   <= RESP_OOR;
        end
      end
    end
  end

  // One register per slot; each is written only by its own decode.
  for (genvar g = 0; g < NSLOT; g++) begin : g_reg
    logic [DW-1:0] q;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN)
        q <= '0;
      else if (commit && wr_in_range && (wr_idx[IDX_W-1:0] == IDX_W'(g)))
        q <= merge(q, wr_data, wr_strb);
    end
    assign regs[g] = q;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (ar_hs)        r_state_nxt = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default:                  r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = up & (r_state == R_IDLE);
    S_AXI_RVALID  = (r_state == R_DATA);
  end

  // Sampled with the pre-commit bank, so a read racing a write sees the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      if (rd_in_range) begin
        S_AXI_RDATA <= regs[rd_idx[IDX_W-1:0]];
        S_AXI_RRESP <= RESP_OKAY;
      end else begin
        S_AXI_RDATA <= '0;
        S_AXI_RRESP <= RESP_OOR;
      end
    end
  end

endmodule
